// File: rtl/pll_md_reconfig_if.sv
// Request/status and PLLA MD-port bundle for pll_md_reconfig.
// slave = the sequencer; master = host control logic together with the PLL wrapper.
interface pll_md_reconfig_if #(
    parameter int NUM_CH = 7
);
    localparam int SEL_W = $clog2(NUM_CH + 1);

    logic             req_valid;
    logic [SEL_W-1:0] req_sel;
    logic [7:0]       req_val;
    logic             req_ready;
    logic             busy;
    logic             done;
    logic [1:0]       err;
    logic [1:0]       mdopc;
    logic             mdainc;
    logic [7:0]       mdwdi;
    logic [7:0]       mdrdo;
    logic             pll_rst;
    logic             pll_lock;

    modport master (
        output req_valid, req_sel, req_val, mdrdo, pll_lock,
        input  req_ready, busy, done, err, mdopc, mdainc, mdwdi, pll_rst
    );

    modport slave (
        input  req_valid, req_sel, req_val, mdrdo, pll_lock,
        output req_ready, busy, done, err, mdopc, mdainc, mdwdi, pll_rst
    );
endinterface

// File: rtl/pll_md_reconfig.sv
// PLLA MD-port reconfiguration sequencer: writes one ODIVk/MDIV register, pulses pll_rst, waits for lock.
// Define PLL_MD_READBACK_EN to re-read the written register and verify it before resetting the PLL.
module pll_md_reconfig #(
    parameter int         NUM_CH       = 7,
    parameter logic [7:0] ODIV_BASE    = 8'd2,
    parameter logic [7:0] MDIV_ADDR    = 8'd1,
    parameter int         RST_CYCLES   = 16,
    parameter int         LOCK_TIMEOUT = 65535,
    parameter int         READ_LAT     = 2
) (
    input  logic             mdclk_i,
    input  logic             reset_n_i,
    pll_md_reconfig_if.slave bus
);
    localparam int SEL_W = $clog2(NUM_CH + 1);

    localparam logic [1:0] OPC_NOP = 2'b00;
    localparam logic [1:0] OPC_WR  = 2'b01;
    localparam logic [1:0] OPC_RD  = 2'b10;
    localparam logic [1:0] OPC_CLR = 2'b11;

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_SEL  = 2'b01;
    localparam logic [1:0] ERR_LOCK = 2'b10;
    localparam logic [1:0] ERR_RB   = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE, S_CLR, S_SEEK, S_WRITE, S_RD, S_RWAIT, S_PRST, S_WLOCK, S_DONE, S_ERR
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      cnt_q, cnt_d;
    logic [7:0]       addr_q, addr_d;
    logic [7:0]       val_q, val_d;
    logic             rb_pass_q, rb_pass_d;
    logic [1:0]       err_q, err_d;
    logic [1:0]       mdopc_q, mdopc_d;
    logic             mdainc_q, mdainc_d;
    logic [7:0]       mdwdi_q, mdwdi_d;
    logic             pll_rst_q, pll_rst_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic [SEL_W-1:0] sel_s;
    logic             accept_s;

    assign sel_s    = bus.req_sel;
    assign accept_s = bus.req_valid && (state_q == S_IDLE);

    // Next-state logic plus next values of the registered MD/status outputs
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        val_d     = val_q;
        rb_pass_d = rb_pass_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    val_d     = bus.req_val;
                    rb_pass_d = 1'b0;
                    if (int'(sel_s) > NUM_CH) begin
                        err_d   = ERR_SEL;
                        state_d = S_ERR;
                    end else begin
                        err_d   = ERR_OK;
                        state_d = S_CLR;
                        addr_d  = (int'(sel_s) == NUM_CH) ? MDIV_ADDR : ODIV_BASE + 8'(sel_s);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLR: begin
                if (addr_q == 8'd0) begin
                    state_d = rb_pass_q ? S_RD : S_WRITE;
                end else begin
                    state_d = S_SEEK;
                    cnt_d   = {24'd0, addr_q} - 32'd1;
                end
            end
            S_SEEK: begin
                if (cnt_q == 32'd0) begin
                    state_d = rb_pass_q ? S_RD : S_WRITE;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            S_WRITE: begin
`ifdef PLL_MD_READBACK_EN
                state_d   = S_CLR;
                rb_pass_d = 1'b1;
`else
                state_d   = S_PRST;
                cnt_d     = 32'(RST_CYCLES - 1);
`endif
            end
            S_RD: begin
                state_d = S_RWAIT;
                cnt_d   = 32'(READ_LAT - 1);
            end
            // mdrdo is only trusted on the last wait cycle
            S_RWAIT: begin
                if (cnt_q == 32'd0) begin
                    if (bus.mdrdo == val_q) begin
                        state_d = S_PRST;
                        cnt_d   = 32'(RST_CYCLES - 1);
                    end else begin
                        state_d = S_ERR;
                        err_d   = ERR_RB;
                    end
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            S_PRST: begin
                if (cnt_q == 32'd0) begin
                    state_d = S_WLOCK;
                    cnt_d   = 32'd0;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            S_WLOCK: begin
                if (bus.pll_lock) begin
                    state_d = S_DONE;
                end else if (cnt_q == 32'(LOCK_TIMEOUT - 1)) begin
                    state_d = S_ERR;
                    err_d   = ERR_LOCK;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_DONE: begin
                err_d   = ERR_OK;
                state_d = S_IDLE;
            end
            S_ERR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        case (state_d)
            S_CLR:   mdopc_d = OPC_CLR;
            S_WRITE: mdopc_d = OPC_WR;
            S_RD:    mdopc_d = OPC_RD;
            default: mdopc_d = OPC_NOP;
        endcase
        mdainc_d  = (state_d == S_SEEK);
        mdwdi_d   = (state_d == S_WRITE) ? val_d : 8'd0;
        pll_rst_d = (state_d == S_PRST);
        done_d    = (state_d == S_DONE);
        busy_d    = (state_d != S_IDLE);
    end

    // State, datapath and output registers with synchronous active-low reset
    always_ff @(posedge mdclk_i) begin
        if (!reset_n_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= 32'd0;
            addr_q    <= 8'd0;
            val_q     <= 8'd0;
            rb_pass_q <= 1'b0;
            err_q     <= ERR_OK;
            mdopc_q   <= OPC_NOP;
            mdainc_q  <= 1'b0;
            mdwdi_q   <= 8'd0;
            pll_rst_q <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            val_q     <= val_d;
            rb_pass_q <= rb_pass_d;
            err_q     <= err_d;
            mdopc_q   <= mdopc_d;
            mdainc_q  <= mdainc_d;
            mdwdi_q   <= mdwdi_d;
            pll_rst_q <= pll_rst_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.req_ready = ~busy_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.mdopc     = mdopc_q;
    assign bus.mdainc    = mdainc_q;
    assign bus.mdwdi     = mdwdi_q;
    assign bus.pll_rst   = pll_rst_q;
endmodule

// File: tb/tb_pll_md_reconfig.sv
// Scoreboard bench for pll_md_reconfig: directed requests push expected per-transaction
// activity counts; a negedge monitor tallies MD/PLL activity and compares when busy falls.
`timescale 1ns/1ps
module tb_pll_md_reconfig;
    localparam int READ_LAT = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       req_valid = 1'b0;
    logic [2:0] req_sel = 3'd0;
    logic [7:0] req_val = 8'd0;
    logic [7:0] rb_data = 8'd0;
    logic       lock = 1'b1;
    logic [1:0] lock_mode = 2'd0;   // 0: lock 20 cycles after pll_rst falls, 1: never, 2: always high
    logic       use_b = 1'b0;
    logic       mon_en = 1'b0;

    always #5 clk = ~clk;

    pll_md_reconfig_if #(.NUM_CH(7)) ifa ();
    pll_md_reconfig_if #(.NUM_CH(5)) ifb ();

    pll_md_reconfig #(.NUM_CH(7), .LOCK_TIMEOUT(100), .READ_LAT(READ_LAT)) dut (
        .mdclk_i(clk), .reset_n_i(reset_n), .bus(ifa.slave));
    pll_md_reconfig #(.NUM_CH(5), .ODIV_BASE(8'd0), .LOCK_TIMEOUT(100), .READ_LAT(READ_LAT)) dut_b (
        .mdclk_i(clk), .reset_n_i(reset_n), .bus(ifb.slave));

    assign ifa.req_valid = req_valid & ~use_b;
    assign ifa.req_sel   = req_sel;
    assign ifa.req_val   = req_val;
    assign ifa.mdrdo     = rb_data;
    assign ifa.pll_lock  = lock;
    assign ifb.req_valid = req_valid & use_b;
    assign ifb.req_sel   = req_sel;
    assign ifb.req_val   = req_val;
    assign ifb.mdrdo     = rb_data;
    assign ifb.pll_lock  = lock;

    logic       o_busy, o_ready, o_done, o_mdainc, o_pll_rst;
    logic [1:0] o_err, o_mdopc;
    logic [7:0] o_mdwdi;
    assign o_busy    = use_b ? ifb.busy      : ifa.busy;
    assign o_ready   = use_b ? ifb.req_ready : ifa.req_ready;
    assign o_done    = use_b ? ifb.done      : ifa.done;
    assign o_mdainc  = use_b ? ifb.mdainc    : ifa.mdainc;
    assign o_pll_rst = use_b ? ifb.pll_rst   : ifa.pll_rst;
    assign o_err     = use_b ? ifb.err       : ifa.err;
    assign o_mdopc   = use_b ? ifb.mdopc     : ifa.mdopc;
    assign o_mdwdi   = use_b ? ifb.mdwdi     : ifa.mdwdi;

    typedef struct {
        logic [1:0] err;
        int         done;
        int         clr;
        int         ainc;
        int         wr;
        logic [7:0] wdata;
        int         rd;
        int         rst;
        int         wlock;
        int         busy;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   pushed = 0;
    int   m_txns = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // PLL lock model: lock drops while pll_rst is high and returns 20 cycles after it falls
    initial begin : lock_model
        int lk_cnt;
        lk_cnt = 0;
        forever begin
            @(negedge clk);
            if (lock_mode == 2'd2) begin
                lock = 1'b1;
            end else if (o_pll_rst) begin
                lock   = 1'b0;
                lk_cnt = 0;
            end else if (!lock && lock_mode == 2'd0) begin
                lk_cnt++;
                if (lk_cnt >= 20) lock = 1'b1;
            end
        end
    end

    // Monitor: tally activity during busy, compare against the scoreboard when busy falls
    initial begin : monitor
        exp_t e;
        bit active;
        int m_done, m_clr, m_ainc, m_wr, m_rd, m_rst, m_wlock, m_busy;
        logic [7:0] m_wdata;
        bit m_seen_rst;
        active = 1'b0;
        forever begin
            @(negedge clk);
            if (!mon_en) continue;
            if (o_busy === 1'b1) begin
                if (!active) begin
                    active = 1'b1;
                    m_done = 0; m_clr = 0; m_ainc = 0; m_wr = 0; m_rd = 0;
                    m_rst = 0; m_wlock = 0; m_busy = 0; m_wdata = 8'd0; m_seen_rst = 1'b0;
                end
                m_busy++;
                if (o_done) m_done++;
                if (o_mdopc == 2'b11) m_clr++;
                if (o_mdopc == 2'b10) m_rd++;
                if (o_mdopc == 2'b01) begin
                    m_wr++;
                    m_wdata = o_mdwdi;
                end
                if (o_mdainc) m_ainc++;
                if (o_pll_rst) begin
                    m_rst++;
                    m_seen_rst = 1'b1;
                end else if (m_seen_rst && !o_done && o_err == 2'b00) begin
                    m_wlock++;
                end
            end else if (active) begin
                active = 1'b0;
                m_txns++;
                chk("sb_nonempty", (exp_q.size() > 0) ? 1 : 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("err", o_err, e.err);
                    chk("ready", o_ready, 1);
                    chk("done_pulses", m_done, e.done);
                    chk("clr_cycles", m_clr, e.clr);
                    chk("ainc_pulses", m_ainc, e.ainc);
                    chk("write_cycles", m_wr, e.wr);
                    chk("write_data", m_wdata, e.wdata);
                    chk("read_cycles", m_rd, e.rd);
                    chk("pll_rst_cycles", m_rst, e.rst);
                    chk("wlock_cycles", m_wlock, e.wlock);
                    chk("busy_cycles", m_busy, e.busy);
                end
            end else begin
                chk("idle_quiet", {o_mdopc, o_mdainc, o_pll_rst, o_done}, 0);
            end
        end
    end

    task automatic issue(input bit b, input logic [2:0] sel, input logic [7:0] val, input int addr,
                         input logic [1:0] lm, input bit rb_bad, input bit ign, input bit abort,
                         input logic [1:0] e_err, input int e_done, input int e_ainc,
                         input int e_rst, input int e_wlock, input int e_busy);
        exp_t e;
        bit md;
        md      = (e_err != 2'b01);
        e.err   = e_err;
        e.done  = e_done;
        e.clr   = md ? 1 : 0;
        e.ainc  = e_ainc;
        e.wr    = md ? 1 : 0;
        e.wdata = md ? val : 8'd0;
        e.rd    = 0;
        e.rst   = e_rst;
        e.wlock = e_wlock;
        e.busy  = e_busy;
`ifdef PLL_MD_READBACK_EN
        if (md) begin
            e.clr  += 1;
            e.ainc += addr;
            e.rd    = 1;
            e.busy += addr + 2 + READ_LAT;
        end
`endif
        @(negedge clk);
        use_b     = b;
        lock_mode = lm;
        rb_data   = rb_bad ? (val ^ 8'h01) : val;
        exp_q.push_back(e);
        pushed++;
        req_sel   = sel;
        req_val   = val;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        if (abort) begin
            for (int i = 0; i < 200 && !o_pll_rst; i++) @(negedge clk);
            chk("abort_prst_seen", o_pll_rst, 1);
            repeat (4) @(negedge clk);
            reset_n = 1'b0;
            @(negedge clk);
            reset_n = 1'b1;
            chk("abort_pll_rst", o_pll_rst, 0);
            chk("abort_busy", o_busy, 0);
            chk("abort_ready", o_ready, 1);
        end
        for (int i = 0; i < 2000 && o_busy; i++) begin
            if (ign && i == 5) begin
                req_sel   = 3'd0;
                req_val   = 8'd99;
                req_valid = 1'b1;
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("busy_timeout", o_busy, 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", o_busy, 0);
        chk("rst_ready", o_ready, 1);
        chk("rst_mdopc", o_mdopc, 0);
        chk("rst_mdainc", o_mdainc, 0);
        chk("rst_mdwdi", o_mdwdi, 0);
        chk("rst_pll_rst", o_pll_rst, 0);
        chk("rst_done", o_done, 0);
        chk("rst_err", o_err, 0);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        repeat (2) @(negedge clk);

        //    b     sel   val     addr lm    bad  ign  abrt err    dn ainc rst wlk busy
        issue(1'b0, 3'd0, 8'd12,  2,   2'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1, 2, 16, 20, 41);
        issue(1'b0, 3'd7, 8'd30,  1,   2'd0, 1'b0, 1'b1, 1'b0, 2'b00, 1, 1, 16, 20, 40);
        issue(1'b0, 3'd3, 8'd55,  5,   2'd1, 1'b0, 1'b0, 1'b0, 2'b10, 0, 5, 16, 100, 124);
        issue(1'b1, 3'd7, 8'd9,   0,   2'd0, 1'b0, 1'b0, 1'b0, 2'b01, 0, 0, 0,  0,  1);
        issue(1'b0, 3'd0, 8'd12,  2,   2'd2, 1'b0, 1'b0, 1'b0, 2'b00, 1, 2, 16, 1,  22);
        issue(1'b0, 3'd0, 8'd77,  2,   2'd0, 1'b0, 1'b0, 1'b1, 2'b00, 0, 2, 5,  0,  9);
        issue(1'b0, 3'd6, 8'd200, 8,   2'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1, 8, 16, 20, 47);
        issue(1'b1, 3'd0, 8'd5,   0,   2'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1, 0, 16, 20, 39);
        issue(1'b1, 3'd5, 8'hA5,  1,   2'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1, 1, 16, 20, 40);
`ifdef PLL_MD_READBACK_EN
        issue(1'b0, 3'd1, 8'h40,  3,   2'd0, 1'b1, 1'b0, 1'b0, 2'b11, 0, 3, 0,  0,  6);
`endif

        repeat (10) @(negedge clk);
        chk("sb_empty", exp_q.size(), 0);
        chk("txn_count", m_txns, pushed);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
